uart_mmio: RTL and testbench

// - Memory-mapped UART controller downstream of the single-cycle CPU data path; decodes the ALU address and rd/wr strobes.
// - Provides TX and RX byte registers, status/control, and a level interrupt into the CPU IRQ path.
// - Frame format: 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit). RX uses 16x oversampling.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_mmio.sv | 214 +++++++++++++++++++++
 tb/tb_uart_mmio.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, CON bit
// positions and the state encoding used by both serial FSMs.
package uart_pkg;

   localparam logic [31:0] TXD_OFS = 32'd0;
   localparam logic [31:0] RXD_OFS = 32'd4;
   localparam logic [31:0] CON_OFS = 32'd8;

   localparam int unsigned CON_TX_BUSY   = 0;
   localparam int unsigned CON_RX_VALID  = 1;
   localparam int unsigned CON_OVERRUN   = 2;
   localparam int unsigned CON_FRAME_ERR = 3;
   localparam int unsigned CON_RX_IRQ_EN = 4;
   localparam int unsigned CON_TX_DONE   = 5;
   localparam int unsigned CON_W         = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversample tick generator; tick is high for the one clk
// in which the counter wraps from DIV-1 back to 0.
module uart_baud_gen #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: bus decode, TXD/RXD/CON registers, TX and RX FSMs
// sharing one 16x oversample tick, and a level RX interrupt.
module uart_mmio
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BAUD      = 9600,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irqout,
   input  logic        uart_rx,
   output logic        uart_tx
);

   localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);

   logic tick;

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   logic sel_txd, sel_rxd, sel_con;
   logic txd_wr, rxd_rd, con_rd, con_wr;
   logic unused_wdata;

   assign sel_txd = (addr == BASE_ADDR + TXD_OFS);
   assign sel_rxd = (addr == BASE_ADDR + RXD_OFS);
   assign sel_con = (addr == BASE_ADDR + CON_OFS);
   assign txd_wr  = wr & sel_txd;
   assign rxd_rd  = rd & sel_rxd;
   assign con_rd  = rd & sel_con;
   assign con_wr  = wr & sel_con;
   assign unused_wdata = ^wdata[31:8];

   uart_state_t tx_state, rx_state;
   logic [3:0]  tx_tick_cnt, rx_tick_cnt;
   logic [2:0]  tx_bit_cnt, rx_bit_cnt;
   logic [7:0]  tx_shift, rx_shift, rxd;
   logic        tx_busy, tx_done, rx_valid, overrun, frame_err, rx_irq_en;
   logic [1:0]  rx_sync;
   logic        rx_s, tx_bit_end, tx_finish, tx_load, rx_bit_end;
   logic [CON_W-1:0] con_val;

   assign rx_s       = rx_sync[1];
   assign tx_bit_end = tick && (tx_tick_cnt == 4'd15);
   assign rx_bit_end = tick && (rx_tick_cnt == 4'd15);
   assign tx_finish  = (tx_state == ST_STOP) && tx_bit_end;
   // The cycle that ends the stop bit already counts as idle for a new write.
   assign tx_load    = txd_wr && (!tx_busy || tx_finish);

   always_comb begin
      con_val                = '0;
      con_val[CON_TX_BUSY]   = tx_busy;
      con_val[CON_RX_VALID]  = rx_valid;
      con_val[CON_OVERRUN]   = overrun;
      con_val[CON_FRAME_ERR] = frame_err;
      con_val[CON_RX_IRQ_EN] = rx_irq_en;
      con_val[CON_TX_DONE]   = tx_done;
   end

   always_comb begin
      rdata = '0;
      if (rxd_rd)
         rdata = {24'd0, rxd};
      else if (con_rd)
         rdata = {{(32-CON_W){1'b0}}, con_val};
   end

   assign irqout = rx_irq_en & rx_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rx_irq_en <= 1'b0;
      else if (con_wr)
         rx_irq_en <= wdata[CON_RX_IRQ_EN];
   end

   // A loaded byte waits in IDLE with tx_busy set until the next tick starts the frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state    <= ST_IDLE;
         tx_tick_cnt <= '0;
         tx_bit_cnt  <= '0;
         tx_shift    <= '0;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
         uart_tx     <= 1'b1;
      end else begin
         if (con_rd)
            tx_done <= 1'b0;
         if (tick)
            tx_tick_cnt <= tx_tick_cnt + 1'b1;
         case (tx_state)
            ST_IDLE: begin
               if (tx_busy && tick) begin
                  tx_state    <= ST_START;
                  tx_tick_cnt <= '0;
                  uart_tx     <= 1'b0;
               end
            end
            ST_START: begin
               if (tx_bit_end) begin
                  tx_state   <= ST_DATA;
                  tx_bit_cnt <= '0;
                  uart_tx    <= tx_shift[0];
                  tx_shift   <= {1'b0, tx_shift[7:1]};
               end
            end
            ST_DATA: begin
               if (tx_bit_end) begin
                  tx_bit_cnt <= tx_bit_cnt + 1'b1;
                  if (tx_bit_cnt == 3'd7) begin
                     tx_state <= ST_STOP;
                     uart_tx  <= 1'b1;
                  end else begin
                     uart_tx  <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                  end
               end
            end
            ST_STOP: begin
               if (tx_bit_end) begin
                  tx_state <= ST_IDLE;
                  tx_busy  <= 1'b0;
                  tx_done  <= 1'b1;
               end
            end
            default: tx_state <= ST_IDLE;
         endcase
         if (tx_load) begin
            tx_shift <= wdata[7:0];
            tx_busy  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rx_sync <= 2'b11;
      else
         rx_sync <= {rx_sync[0], uart_rx};
   end

   // Clears are written before the FSM so a flag set in the same cycle wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state    <= ST_IDLE;
         rx_tick_cnt <= '0;
         rx_bit_cnt  <= '0;
         rx_shift    <= '0;
         rxd         <= '0;
         rx_valid    <= 1'b0;
         overrun     <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         if (rxd_rd)
            rx_valid <= 1'b0;
         if (con_rd) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
         end
         if (tick)
            rx_tick_cnt <= rx_tick_cnt + 1'b1;
         case (rx_state)
            ST_IDLE: begin
               if (!rx_s) begin
                  rx_state    <= ST_START;
                  rx_tick_cnt <= '0;
               end
            end
            ST_START: begin
               if (tick && (rx_tick_cnt == 4'd7)) begin
                  rx_tick_cnt <= '0;
                  rx_bit_cnt  <= '0;
                  rx_state    <= rx_s ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (rx_bit_end) begin
                  rx_shift   <= {rx_s, rx_shift[7:1]};
                  rx_bit_cnt <= rx_bit_cnt + 1'b1;
                  if (rx_bit_cnt == 3'd7)
                     rx_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (rx_bit_end) begin
                  rx_state <= ST_IDLE;
                  if (rx_s) begin
                     rxd      <= rx_shift;
                     rx_valid <= 1'b1;
                     if (rx_valid && !rxd_rd)
                        overrun <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            default: rx_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register-level model plus serial line
// driver/decoder, directed scenarios followed by randomized traffic.
module tb_uart_mmio;

   localparam int unsigned CLK_FREQ = 1_600_000;
   localparam int unsigned BAUD     = 10_000;
   localparam int unsigned DIV      = CLK_FREQ / (BAUD * 16);
   localparam int unsigned BIT_CLK  = DIV * 16;
   localparam logic [31:0] BASE  = 32'h4000_0018;
   localparam logic [31:0] A_TXD = BASE;
   localparam logic [31:0] A_RXD = BASE + 32'd4;
   localparam logic [31:0] A_CON = BASE + 32'd8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd = 1'b0, wr = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata;
   logic        irqout;
   logic        uart_rx = 1'b1;
   logic        uart_tx;

   always #5 clk = ~clk;

   uart_mmio #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .BASE_ADDR(BASE)) dut (
      .clk     (clk),
      .reset   (reset),
      .rd      (rd),
      .wr      (wr),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .irqout  (irqout),
      .uart_rx (uart_rx),
      .uart_tx (uart_tx)
   );

   int vectors = 0;
   int miscompares = 0;

   // Register-level model of the UART as seen from the bus.
   logic [7:0] m_rxd = '0;
   bit m_valid = 0, m_overrun = 0, m_ferr = 0, m_irq_en = 0, m_done = 0, m_busy = 0;
   bit rx_window = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] model_read(logic [31:0] a);
      if (a == A_RXD)
         return {24'd0, m_rxd};
      if (a == A_CON)
         return 32'(m_busy) | (32'(m_valid) << 1) | (32'(m_overrun) << 2) |
                (32'(m_ferr) << 3) | (32'(m_irq_en) << 4) | (32'(m_done) << 5);
      return 32'd0;
   endfunction

   function automatic void model_reset();
      m_rxd = '0; m_valid = 0; m_overrun = 0; m_ferr = 0;
      m_irq_en = 0; m_done = 0; m_busy = 0;
   endfunction

   // Compare process: every cycle, on the falling edge.
   always @(negedge clk) begin
      if (!rx_window)
         chk("irqout", {31'd0, irqout}, {31'd0, m_irq_en & m_valid});
      if (!m_busy)
         chk("tx_idle_line", {31'd0, uart_tx}, 32'd1);
      if (rd) begin
         chk("rdata", rdata, model_read(addr));
         if (addr == A_RXD)
            m_valid = 0;
         if (addr == A_CON) begin
            m_overrun = 0; m_ferr = 0; m_done = 0;
         end
      end else begin
         chk("rdata_idle", rdata, 32'd0);
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      wr = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      wr = 1'b0; addr = '0; wdata = '0;
      if (a == A_CON)
         m_irq_en = d[4];
      if (a == A_TXD && !m_busy)
         m_busy = 1;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      rd = 1'b1; addr = a;
      @(negedge clk);
      d = rdata;
      @(posedge clk); #1;
      rd = 1'b0; addr = '0;
   endtask

   task automatic rx_frame(input logic [7:0] b, input bit stop_val, input int unsigned stop_len);
      logic [8:0] bits;
      bits = {b, 1'b0};
      for (int k = 0; k < 9; k++) begin
         uart_rx = bits[k];
         repeat (BIT_CLK) @(posedge clk);
         #1;
      end
      rx_window = 1;
      uart_rx = stop_val;
      repeat (stop_len) @(posedge clk);
      #1;
      uart_rx = 1'b1;
      repeat (BIT_CLK - stop_len + (stop_val ? 0 : 100)) @(posedge clk);
      #1;
      if (stop_val) begin
         if (m_valid)
            m_overrun = 1;
         m_rxd = b;
         m_valid = 1;
      end else begin
         m_ferr = 1;
      end
      rx_window = 0;
   endtask

   // Call right after the TXD write; checks start latency, every bit's value near
   // both ends and the middle of its 160-clk slot, then the return to idle.
   task automatic tx_capture(input logic [7:0] b);
      logic [9:0] frame;
      int unsigned waited;
      int unsigned ofs;
      frame = {1'b1, b, 1'b0};
      waited = 0;
      while (uart_tx !== 1'b0 && waited <= DIV + 1) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("tx_start_latency", 32'(waited <= DIV + 1), 32'd1);
      if (uart_tx !== 1'b0)
         return;
      for (int c = 0; c < 10 * BIT_CLK; c++) begin
         ofs = c % BIT_CLK;
         if (ofs == 2 || ofs == BIT_CLK / 2 || ofs == BIT_CLK - 3)
            chk($sformatf("tx_bit%0d", c / BIT_CLK), {31'd0, uart_tx}, {31'd0, frame[c / BIT_CLK]});
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      m_busy = 0;
      m_done = 1;
   endtask

   initial begin
      #200_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int unsigned waited;

      // Reset
      #1 reset = 1'b0;
      model_reset();
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset_tx", {31'd0, uart_tx}, 32'd1);
      chk("reset_irq", {31'd0, irqout}, 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      bus_read(A_CON, v);
      chk("reset_con", v, 32'h0);

      // TX 0x55 with a dropped write of 0xAA mid-frame
      bus_write(A_TXD, 32'h55);
      fork
         tx_capture(8'h55);
         begin
            bus_read(A_CON, v);
            chk("con_tx_busy", v, 32'h01);
            repeat (500) @(posedge clk);
            #1;
            bus_write(A_TXD, 32'hAA);
         end
      join
      bus_read(A_CON, v);
      chk("con_tx_done", v, 32'h20);
      bus_read(A_CON, v);
      chk("con_done_cleared", v, 32'h00);
      repeat (2 * BIT_CLK) @(posedge clk);
      #1;

      // RX + interrupt
      bus_write(A_CON, 32'h10);
      rx_frame(8'hA3, 1, BIT_CLK);
      @(negedge clk);
      chk("irq_after_rx", {31'd0, irqout}, 32'd1);
      bus_read(A_RXD, v);
      chk("rxd_a3", v, 32'hA3);
      @(negedge clk);
      chk("irq_after_rxd_read", {31'd0, irqout}, 32'd0);
      bus_read(A_CON, v);
      chk("con_after_rxd_read", v, 32'h10);

      // Overrun: two back-to-back frames
      rx_frame(8'h11, 1, BIT_CLK);
      rx_frame(8'h22, 1, BIT_CLK);
      bus_read(A_CON, v);
      chk("con_overrun", v, 32'h16);
      bus_read(A_CON, v);
      chk("con_overrun_cleared", v, 32'h12);
      bus_read(A_RXD, v);
      chk("rxd_22", v, 32'h22);
      bus_write(A_CON, 32'h0);

      // Frame error, then a short glitch
      rx_frame(8'h7E, 0, 100);
      bus_read(A_CON, v);
      chk("con_frame_err", v, 32'h08);
      bus_read(A_CON, v);
      chk("con_ferr_cleared", v, 32'h00);
      uart_rx = 1'b0;
      repeat (40) @(posedge clk);
      #1 uart_rx = 1'b1;
      repeat (300) @(posedge clk);
      bus_read(A_CON, v);
      chk("con_after_glitch", v, 32'h00);
      bus_read(A_RXD, v);
      chk("rxd_unchanged", v, 32'h22);

      // Reset in the middle of a TX frame
      bus_write(A_TXD, 32'h3C);
      waited = 0;
      while (uart_tx !== 1'b0 && waited <= DIV + 1) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("rst_test_start", 32'(waited <= DIV + 1), 32'd1);
      repeat (5 * BIT_CLK + 80) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      @(negedge clk);
      chk("tx_abort", {31'd0, uart_tx}, 32'd1);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      bus_read(A_CON, v);
      chk("con_after_reset", v, 32'h00);
      bus_write(A_TXD, 32'hC3);
      tx_capture(8'hC3);

      // Randomized traffic
      for (int it = 0; it < 24; it++) begin
         int unsigned op;
         logic [7:0]  b, b2;
         logic [31:0] a;
         bit          s;
         op = $urandom_range(0, 5);
         b  = 8'($urandom());
         b2 = 8'($urandom());
         case (op)
            0: begin
               s = ($urandom_range(0, 3) != 0);
               rx_frame(b, s, s ? BIT_CLK : 100);
               if (s && $urandom_range(0, 1) == 1)
                  rx_frame(b2, 1, BIT_CLK);
            end
            1: begin
               bus_write(A_TXD, {24'd0, b});
               tx_capture(b);
            end
            2: begin
               a = (b[1:0] == 2'd0) ? A_TXD : (b[0] ? A_RXD : A_CON);
               bus_read(a, v);
            end
            3: begin
               a = $urandom();
               if (a == A_TXD)
                  a = a ^ 32'h100;
               if (b[0])
                  bus_read(a, v);
               else
                  bus_write(a, $urandom());
            end
            4: bus_write(A_CON, $urandom());
            default: begin
               fork
                  rx_frame(b, 1, BIT_CLK);
                  begin
                     bus_write(A_TXD, {24'd0, b2});
                     tx_capture(b2);
                  end
               join
            end
         endcase
         repeat (20) @(posedge clk);
         #1;
      end
      bus_read(A_CON, v);
      bus_read(A_RXD, v);
      bus_read(A_CON, v);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
